fb_write_arbiter: RTL

- Shares the single VGA frame-buffer write port (8-bit pixel byte, 16-bit linear address) between NREQ independent writers, such as the hex character engine and a cursor/overlay writer.
- Arbitration is round-robin with a valid/ready handshake.
- Contains a built-in screen-clear sequencer that fills the whole frame buffer with a constant byte, locking out all requesters while it runs.
- Sits between the display writers and the dual-port frame-buffer RAM that the VGA scan-out reads.

---
 rtl/fb_write_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: round-robin sharing of one 8-bit/16-bit-address
// write port among NREQ writers, plus a full-screen clear sweep that locks them out.
module fb_write_arbiter #(
  parameter int         NREQ       = 2,
  parameter int         FB_DEPTH   = 38400,
  parameter logic [7:0] CLEAR_BYTE = 8'h00
) (
  input  logic                 clock25,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_add,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 oob_drop,
  output logic [15:0]          mem_add,
  output logic [7:0]           mem_out,
  output logic                 mem_write
);

  localparam int          PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [16:0] DEPTH_X  = 17'(FB_DEPTH);
  localparam logic [15:0] LAST_ADD = 16'(FB_DEPTH - 1);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state_p0, state_nxt;
  logic [PTR_W-1:0]  rr_ptr_p0, rr_ptr_nxt;
  logic [15:0]       clr_cnt_p0, clr_cnt_nxt;

  logic [15:0]       wr_add_p1, wr_add_nxt;
  logic [7:0]        wr_data_p1, wr_data_nxt;
  logic              vld_p1, vld_nxt;
  logic              oob_p1, oob_nxt;
  logic              busy_p1, busy_nxt;
  logic              done_p1, done_nxt;

  logic              grant_hit;
  logic [PTR_W-1:0]  grant_idx;
  logic [NREQ-1:0]   grant_oh;
  logic [15:0]       grant_add;
  logic [7:0]        grant_data;

  function automatic logic in_bounds(input logic [15:0] add);
    return ({1'b0, add} < DEPTH_X);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) >= NREQ - 1)
      return '0;
    return p + 1'b1;
  endfunction

  // Round-robin search: distance k from rr_ptr, lowest distance wins.
  always_comb begin
    grant_hit  = 1'b0;
    grant_idx  = '0;
    grant_oh   = '0;
    grant_add  = '0;
    grant_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_hit && req_valid[i] &&
            ((int'(rr_ptr_p0) + k == i) || (int'(rr_ptr_p0) + k == i + NREQ))) begin
          grant_hit   = 1'b1;
          grant_idx   = PTR_W'(i);
          grant_oh[i] = 1'b1;
          grant_add   = req_add[16*i +: 16];
          grant_data  = req_data[8*i +: 8];
        end
      end
    end
  end

  // Ready is a pure function of state, pointer and valids.
  always_comb begin
    req_ready = '0;
    if (!reset && (state_p0 == ARB))
      req_ready = grant_oh;
  end

  always_comb begin
    state_nxt   = state_p0;
    rr_ptr_nxt  = rr_ptr_p0;
    clr_cnt_nxt = clr_cnt_p0;
    wr_add_nxt  = wr_add_p1;
    wr_data_nxt = wr_data_p1;
    vld_nxt     = 1'b0;
    oob_nxt     = 1'b0;
    busy_nxt    = busy_p1;
    done_nxt    = 1'b0;
    case (state_p0)
      ARB: begin
        if (grant_hit) begin
          rr_ptr_nxt  = ptr_inc(grant_idx);
          wr_add_nxt  = grant_add;
          wr_data_nxt = grant_data;
          vld_nxt     = in_bounds(grant_add);
          oob_nxt     = !in_bounds(grant_add);
        end
        if (clear_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          busy_nxt    = 1'b1;
        end
      end
      CLEAR: begin
        wr_add_nxt  = clr_cnt_p0;
        wr_data_nxt = CLEAR_BYTE;
        vld_nxt     = 1'b1;
        clr_cnt_nxt = clr_cnt_p0 + 16'd1;
        if (clr_cnt_p0 == LAST_ADD) begin
          state_nxt   = ARB;
          clr_cnt_nxt = '0;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Stage p0 -> p1: control state and the registered write port.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      state_p0   <= ARB;
      rr_ptr_p0  <= '0;
      clr_cnt_p0 <= '0;
      wr_add_p1  <= '0;
      wr_data_p1 <= '0;
      vld_p1     <= 1'b0;
      oob_p1     <= 1'b0;
      busy_p1    <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      rr_ptr_p0  <= rr_ptr_nxt;
      clr_cnt_p0 <= clr_cnt_nxt;
      wr_add_p1  <= wr_add_nxt;
      wr_data_p1 <= wr_data_nxt;
      vld_p1     <= vld_nxt;
      oob_p1     <= oob_nxt;
      busy_p1    <= busy_nxt;
      done_p1    <= done_nxt;
    end
  end

  assign mem_add    = wr_add_p1;
  assign mem_out    = wr_data_p1;
  assign mem_write  = vld_p1;
  assign oob_drop   = oob_p1;
  assign clear_busy = busy_p1;
  assign clear_done = done_p1;

endmodule
